// File: rtl/button_press_classifier.sv
// button_press_classifier: classifies debounced button gestures into short, long and double presses
module button_press_classifier #(
  parameter int LONG_LIMIT = 12_500_000,
  parameter int DOUBLE_GAP = 6_250_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Debounced,
  output logic o_Short_Pulse,
  output logic o_Long_Pulse,
  output logic o_Double_Pulse,
  output logic o_Long_Held,
  output logic o_Busy
);
  localparam int MAX_LIM = LONG_LIMIT > DOUBLE_GAP ? LONG_LIMIT : DOUBLE_GAP;
  localparam int CW = $clog2(MAX_LIM);
  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HOLD, GAP, PRESS2} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic r_Prev, short_nxt, long_nxt, dbl_nxt;
  // Next-state, counter and pulse decode; the counter restarts on any state change
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    short_nxt = 1'b0;
    long_nxt = 1'b0;
    dbl_nxt = 1'b0;
    case (state)
      IDLE: nxt = (i_Debounced && !r_Prev) ? PRESS1 : IDLE;
      PRESS1:
        if (!i_Debounced) nxt = GAP;
        else if (cnt == CW'(LONG_LIMIT - 1)) begin
          nxt = LONG_HOLD;
          long_nxt = 1'b1;
        end else cnt_nxt = cnt + CW'(1);
      LONG_HOLD: nxt = i_Debounced ? LONG_HOLD : IDLE;
      GAP:
        if (i_Debounced) nxt = PRESS2;
        else if (cnt == CW'(DOUBLE_GAP - 1)) begin
          nxt = IDLE;
          short_nxt = 1'b1;
        end else cnt_nxt = cnt + CW'(1);
      PRESS2:
        if (!i_Debounced) begin
          nxt = IDLE;
          dbl_nxt = 1'b1;
        end
      default: nxt = IDLE;
    endcase
    cnt_nxt = (nxt != state) ? '0 : cnt_nxt;
  end
  // State, edge history and registered outputs; r_Prev resets high so a held button is ignored
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      cnt <= '0;
      r_Prev <= 1'b1;
      o_Short_Pulse <= 1'b0;
      o_Long_Pulse <= 1'b0;
      o_Double_Pulse <= 1'b0;
      o_Long_Held <= 1'b0;
      o_Busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      r_Prev <= i_Debounced;
      o_Short_Pulse <= short_nxt;
      o_Long_Pulse <= long_nxt;
      o_Double_Pulse <= dbl_nxt;
      o_Long_Held <= nxt == LONG_HOLD;
      o_Busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_button_press_classifier.sv
// tb_button_press_classifier: gesture-level model plus directed gesture checks
module tb_button_press_classifier;
  localparam int LL = 8;
  localparam int DG = 5;
  logic i_Clk = 1'b0, i_Rst, i_Debounced;
  logic o_Short_Pulse, o_Long_Pulse, o_Double_Pulse, o_Long_Held, o_Busy;
  int checks = 0, errors = 0, cyc = 0;
  int n_short, n_long, n_dbl, n_held, n_busy, t_short, t_long, t_dbl;
  int m_phase, m_hi, m_lo;
  bit valid = 0, m_long, m_prev, e_short, e_long, e_dbl;
  button_press_classifier #(.LONG_LIMIT(LL), .DOUBLE_GAP(DG)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Debounced(i_Debounced),
    .o_Short_Pulse(o_Short_Pulse), .o_Long_Pulse(o_Long_Pulse), .o_Double_Pulse(o_Double_Pulse),
    .o_Long_Held(o_Long_Held), .o_Busy(o_Busy)
  );
  always #5 i_Clk = ~i_Clk;
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask
  // Gesture model: phase 0 idle, 1 first press or its gap, 2 second press; counts run lengths
  always @(posedge i_Clk) begin
    e_short = 0;
    e_long = 0;
    e_dbl = 0;
    if (i_Rst) begin
      valid = 1;
      m_phase = 0;
      m_long = 0;
      m_hi = 0;
      m_lo = 0;
      m_prev = 1;
    end else begin
      if (m_phase == 0) begin
        if (i_Debounced && !m_prev) begin
          m_phase = 1;
          m_hi = 1;
          m_lo = 0;
        end
      end else if (m_long) begin
        if (!i_Debounced) begin
          m_long = 0;
          m_phase = 0;
        end
      end else if (m_phase == 1) begin
        if (i_Debounced && m_lo == 0) begin
          m_hi++;
          if (m_hi == LL + 1) begin
            m_long = 1;
            e_long = 1;
          end
        end else if (i_Debounced) m_phase = 2;
        else begin
          m_lo++;
          if (m_lo == DG + 1) begin
            e_short = 1;
            m_phase = 0;
          end
        end
      end else if (!i_Debounced) begin
        e_dbl = 1;
        m_phase = 0;
      end
      m_prev = i_Debounced;
    end
    cyc++;
  end
  // Per-cycle comparison against the model, plus pulse bookkeeping for the directed checks
  always @(negedge i_Clk) begin
    if (valid) begin
      chk("short", int'(o_Short_Pulse), int'(e_short));
      chk("long", int'(o_Long_Pulse), int'(e_long));
      chk("double", int'(o_Double_Pulse), int'(e_dbl));
      chk("held", int'(o_Long_Held), int'(m_long));
      chk("busy", int'(o_Busy), int'(m_phase != 0));
      if (o_Short_Pulse === 1'b1) begin n_short++; t_short = cyc; end
      if (o_Long_Pulse === 1'b1) begin n_long++; t_long = cyc; end
      if (o_Double_Pulse === 1'b1) begin n_dbl++; t_dbl = cyc; end
      if (o_Long_Held === 1'b1) n_held++;
      if (o_Busy === 1'b1) n_busy++;
    end
  end
  task automatic hold(input logic v, input int n);
    i_Debounced = v;
    repeat (n) @(negedge i_Clk);
  endtask
  task automatic clr;
    n_short = 0; n_long = 0; n_dbl = 0; n_held = 0; n_busy = 0;
    t_short = -1; t_long = -1; t_dbl = -1;
  endtask
  initial begin
    int rise, fall;
    clr();
    i_Rst = 1'b1;
    i_Debounced = 1'b1;
    repeat (3) @(negedge i_Clk);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_pulses", int'({o_Short_Pulse, o_Long_Pulse, o_Double_Pulse, o_Long_Held}), 0);
    i_Rst = 1'b0;
    clr();
    hold(1, 20);
    hold(0, 10);
    chk("holdrst_busy_cycles", n_busy, 0);
    chk("holdrst_pulses", n_short + n_long + n_dbl + n_held, 0);
    clr();
    hold(1, 8);
    fall = cyc + 1;
    hold(0, 10);
    chk("short_count", n_short, 1);
    chk("short_time", t_short, fall + 5);
    chk("short_others", n_long + n_dbl, 0);
    clr();
    rise = cyc + 1;
    hold(1, 9);
    hold(0, 10);
    chk("long_count", n_long, 1);
    chk("long_time", t_long, rise + 8);
    chk("long_held_cycles", n_held, 1);
    chk("long_others", n_short + n_dbl, 0);
    clr();
    rise = cyc + 1;
    hold(1, 12);
    hold(0, 10);
    chk("long12_held_cycles", n_held, 4);
    chk("long12_time", t_long, rise + 8);
    clr();
    hold(1, 3);
    hold(0, 5);
    hold(1, 3);
    fall = cyc + 1;
    hold(0, 10);
    chk("double_count", n_dbl, 1);
    chk("double_time", t_dbl, fall);
    chk("double_short", n_short + n_long, 0);
    clr();
    hold(1, 3);
    hold(0, 6);
    hold(1, 3);
    hold(0, 10);
    chk("gap_short_count", n_short, 2);
    chk("gap_double", n_dbl, 0);
    clr();
    hold(1, 3);
    hold(0, 2);
    hold(1, 20);
    hold(0, 5);
    chk("press2_long_double", n_dbl, 1);
    chk("press2_long_nolong", n_long + n_held, 0);
    clr();
    hold(1, 3);
    hold(0, 2);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("midrst_busy", int'(o_Busy), 0);
    chk("midrst_pulses", int'({o_Short_Pulse, o_Long_Pulse, o_Double_Pulse, o_Long_Held}), 0);
    hold(0, 10);
    chk("midrst_no_short", n_short, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
